// File: rtl/counter_seq_pkg.sv
// Shared types and constants for the counter sequencer.
// Holds the FSM state encoding and the table entry layout.
package counter_seq_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    RUN  = 3'd2,
    NEXT = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam int MATCH_CNT_W   = 16;
  localparam int DEFAULT_WIDTH = 16;

  // One table entry at the default counter width: direction plus limit.
  typedef struct packed {
    logic                     desc;
    logic [DEFAULT_WIDTH-1:0] value;
  } entry_t;

endpackage

// File: rtl/counter_seq_ctrl_if.sv
// Link between the sequencer and one up/down counter instance.
// master = sequencer side, slave = counter side.
interface counter_seq_ctrl_if #(
  parameter int WIDTH = 16
);

  logic             match;
  logic [WIDTH-1:0] setup;
  logic             desc;
  logic             cnt_rst_n;

  modport master (
    input  match,
    output setup,
    output desc,
    output cnt_rst_n
  );

  modport slave (
    output match,
    input  setup,
    input  desc,
    input  cnt_rst_n
  );

endinterface

// File: rtl/counter_seq_table.sv
// Limit table: DEPTH entries of {desc, value}, one synchronous write port,
// one asynchronous read port, cleared by the asynchronous reset.
module counter_seq_table #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [WIDTH:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [WIDTH:0] rdata
);

  logic [WIDTH:0] mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/counter_seq_ctrl.sv
// Sequencer that reloads an up/down counter from a limit table on each match
// rise and replays the table a programmable number of times.
// Optional watchdog: define COUNTER_SEQ_TIMEOUT_EN.
module counter_seq_ctrl
  import counter_seq_pkg::*;
#(
  parameter  int WIDTH          = 16,
  parameter  int DEPTH          = 4,
  parameter  int LOOP_W         = 8,
  parameter  int TIMEOUT_CYCLES = 4096,
  localparam int AW             = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   cfg_we,
  input  logic [AW-1:0]          cfg_addr,
  input  logic [WIDTH-1:0]       cfg_value,
  input  logic                   cfg_desc,
  input  logic [AW:0]            n_entries,
  input  logic [LOOP_W-1:0]      loops,
  counter_seq_ctrl_if.master     cnt,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [AW-1:0]          idx,
  output logic [MATCH_CNT_W-1:0] match_cnt
);

  function automatic logic [AW:0] clamp_entries(input logic [AW:0] n);
    if (n == '0) return (AW+1)'(1);
    if (n > (AW+1)'(DEPTH)) return (AW+1)'(DEPTH);
    return n;
  endfunction

  function automatic logic [LOOP_W-1:0] eff_loops(input logic [LOOP_W-1:0] l);
    return (l == '0) ? LOOP_W'(1) : l;
  endfunction

  state_t                 state_q, state_n;
  logic [AW-1:0]          idx_q, idx_n;
  logic [AW:0]            n_eff_q, n_eff_n;
  logic [LOOP_W-1:0]      loops_q, loops_n;
  logic [MATCH_CNT_W-1:0] match_cnt_q, match_cnt_n;
  logic                   match_q;
  logic                   match_rise;
  logic                   last_entry;
  logic [WIDTH-1:0]       setup_q;
  logic                   desc_q;
  logic                   cnt_rst_n_q;
  logic                   busy_q;
  logic                   done_q;
  logic [WIDTH:0]         rd_data;
  logic                   tbl_we;

  // Table is only writable while the sequencer is parked.
  assign tbl_we = cfg_we && (state_q == IDLE);

  counter_seq_table #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_table (
    .clk   (clk),
    .rst   (rst),
    .we    (tbl_we),
    .waddr (cfg_addr),
    .wdata ({cfg_desc, cfg_value}),
    .raddr (idx_n),
    .rdata (rd_data)
  );

  // A match already high when RUN is entered has match_q set, so it cannot fire.
  assign match_rise = cnt.match & ~match_q;
  assign last_entry = ({1'b0, idx_q} + (AW+1)'(1)) >= n_eff_q;

`ifdef COUNTER_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_q;
  logic            err_q, err_n;
  logic            wd_expired;

  assign wd_expired = (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= (state_q == RUN) ? wd_q + WD_W'(1) : '0;
      err_q <= err_n;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_comb begin
    state_n     = state_q;
    idx_n       = idx_q;
    n_eff_n     = n_eff_q;
    loops_n     = loops_q;
    match_cnt_n = match_cnt_q;
`ifdef COUNTER_SEQ_TIMEOUT_EN
    err_n       = err_q;
`endif
    if (stop) begin
      state_n = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_n     = LOAD;
            idx_n       = '0;
            n_eff_n     = clamp_entries(n_entries);
            loops_n     = eff_loops(loops);
            match_cnt_n = '0;
`ifdef COUNTER_SEQ_TIMEOUT_EN
            err_n       = 1'b0;
`endif
          end
        end
        LOAD: state_n = RUN;
        RUN: begin
          if (match_rise) begin
            state_n     = NEXT;
            match_cnt_n = match_cnt_q + MATCH_CNT_W'(1);
          end
`ifdef COUNTER_SEQ_TIMEOUT_EN
          else if (wd_expired) begin
            state_n = IDLE;
            err_n   = 1'b1;
          end
`endif
        end
        NEXT: begin
          if (!last_entry) begin
            idx_n   = idx_q + AW'(1);
            state_n = LOAD;
          end else if (loops_q > LOOP_W'(1)) begin
            loops_n = loops_q - LOOP_W'(1);
            idx_n   = '0;
            state_n = LOAD;
          end else begin
            state_n = DONE;
          end
        end
        DONE:    state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  // Registered outputs are decoded from the next state so they line up with state_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      n_eff_q     <= '0;
      loops_q     <= '0;
      match_cnt_q <= '0;
      match_q     <= 1'b0;
      setup_q     <= '0;
      desc_q      <= 1'b0;
      cnt_rst_n_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_n;
      idx_q       <= idx_n;
      n_eff_q     <= n_eff_n;
      loops_q     <= loops_n;
      match_cnt_q <= match_cnt_n;
      match_q     <= cnt.match;
      cnt_rst_n_q <= (state_n == RUN) || (state_n == NEXT);
      busy_q      <= (state_n == LOAD) || (state_n == RUN) || (state_n == NEXT);
      done_q      <= (state_n == DONE);
      if (state_n == LOAD) begin
        desc_q  <= rd_data[WIDTH];
        setup_q <= rd_data[WIDTH-1:0];
      end
    end
  end

  assign cnt.setup     = setup_q;
  assign cnt.desc      = desc_q;
  assign cnt.cnt_rst_n = cnt_rst_n_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign idx           = idx_q;
  assign match_cnt     = match_cnt_q;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Directed bench for counter_seq_ctrl: the counter is emulated by driving match by hand.
module tb_counter_seq_ctrl;
  import counter_seq_pkg::*;

  localparam int WIDTH  = 16;
  localparam int DEPTH  = 4;
  localparam int LOOP_W = 8;
  localparam int AW     = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic              cfg_we = 1'b0;
  logic [AW-1:0]     cfg_addr = '0;
  logic [WIDTH-1:0]  cfg_value = '0;
  logic              cfg_desc = 1'b0;
  logic [AW:0]       n_entries = '0;
  logic [LOOP_W-1:0] loops = '0;
  logic              busy, done, err;
  logic [AW-1:0]     idx;
  logic [15:0]       match_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  counter_seq_ctrl_if #(.WIDTH(WIDTH)) cif ();

  counter_seq_ctrl #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .LOOP_W(LOOP_W), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_value(cfg_value), .cfg_desc(cfg_desc),
    .n_entries(n_entries), .loops(loops), .cnt(cif.master),
    .busy(busy), .done(done), .err(err), .idx(idx), .match_cnt(match_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_entry(input int a, input logic [WIDTH-1:0] v, input logic d);
    cfg_we = 1'b1; cfg_addr = AW'(a); cfg_value = v; cfg_desc = d;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic pulse_start(input int n, input int l);
    n_entries = (AW+1)'(n); loops = LOOP_W'(l);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic test_reset();
    cif.match = 1'b0;
    rst = 1'b1;
    step(); step();
    n_checks++;
    if ({cif.setup, cif.desc, cif.cnt_rst_n, busy, done, err, idx, match_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset: setup=%h desc=%b rst_n=%b busy=%b done=%b err=%b idx=%0d cnt=%0d, want all 0",
               cif.setup, cif.desc, cif.cnt_rst_n, busy, done, err, idx, match_cnt);
    end
    rst = 1'b0;
    step();
    n_checks++;
    if ({cif.cnt_rst_n, busy} !== 2'b00) begin
      n_fail++; $display("FAIL idle_after_reset: rst_n,busy=%b want 00", {cif.cnt_rst_n, busy});
    end
  endtask

  task automatic test_table_replay();
    entry_t tbl [3];
    int     k = 0;
    int     loads = 0;
    tbl = '{'{1'b1, 16'h000F}, '{1'b1, 16'h0007}, '{1'b1, 16'h000A}};
    for (int i = 0; i < 3; i++) write_entry(i, tbl[i].value, tbl[i].desc);
    pulse_start(3, 5);
    for (int p = 0; p < 5; p++) begin
      for (int e = 0; e < 3; e++) begin
        n_checks++;
        if ({cif.cnt_rst_n, busy, idx, cif.desc, cif.setup} !== {1'b0, 1'b1, AW'(e), tbl[e]}) begin
          n_fail++;
          $display("FAIL replay_load p%0d e%0d: rst_n=%b busy=%b idx=%0d desc=%b setup=%h want 0 1 %0d %b %h",
                   p, e, cif.cnt_rst_n, busy, idx, cif.desc, cif.setup, e, tbl[e].desc, tbl[e].value);
        end else loads++;
        step();
        n_checks++;
        if ({cif.cnt_rst_n, busy} !== 2'b11) begin
          n_fail++; $display("FAIL replay_run p%0d e%0d: rst_n,busy=%b want 11", p, e, {cif.cnt_rst_n, busy});
        end
        cif.match = 1'b1; step(); cif.match = 1'b0;
        k++;
        n_checks++;
        if (match_cnt !== 16'(k)) begin
          n_fail++; $display("FAIL replay_cnt: match_cnt=%0d want %0d", match_cnt, k);
        end
        step();
      end
    end
    n_checks++;
    if ({done, busy, cif.cnt_rst_n} !== 3'b100 || loads != 15) begin
      n_fail++; $display("FAIL replay_done: done,busy,rst_n=%b loads=%0d want 100 15", {done, busy, cif.cnt_rst_n}, loads);
    end
    step();
    n_checks++;
    if ({done, busy, match_cnt} !== {2'b00, 16'd15}) begin
      n_fail++; $display("FAIL replay_idle: done=%b busy=%b cnt=%0d want 0 0 15", done, busy, match_cnt);
    end
  endtask

  task automatic test_single_entry();
    write_entry(0, 16'h007F, 1'b0);
    pulse_start(1, 1);
    n_checks++;
    if ({cif.setup, cif.desc, cif.cnt_rst_n} !== {16'h007F, 2'b00}) begin
      n_fail++; $display("FAIL single_load: setup=%h desc=%b rst_n=%b want 007f 0 0", cif.setup, cif.desc, cif.cnt_rst_n);
    end
    step();
    cif.match = 1'b1; step(); cif.match = 1'b0;
    n_checks++;
    if ({busy, cif.cnt_rst_n, done, match_cnt} !== {3'b110, 16'd1}) begin
      n_fail++; $display("FAIL single_next: busy=%b rst_n=%b done=%b cnt=%0d want 1 1 0 1", busy, cif.cnt_rst_n, done, match_cnt);
    end
    step();
    n_checks++;
    if ({done, busy, cif.cnt_rst_n} !== 3'b100) begin
      n_fail++; $display("FAIL single_done: done,busy,rst_n=%b want 100", {done, busy, cif.cnt_rst_n});
    end
    step();
    n_checks++;
    if ({done, busy, cif.cnt_rst_n} !== 3'b000) begin
      n_fail++; $display("FAIL single_idle: done,busy,rst_n=%b want 000", {done, busy, cif.cnt_rst_n});
    end
  endtask

  task automatic test_stop();
    pulse_start(3, 1);
    for (int m = 0; m < 2; m++) begin
      step();
      cif.match = 1'b1; step(); cif.match = 1'b0;
      step();
    end
    step();
    pulse_stop();
    n_checks++;
    if ({busy, cif.cnt_rst_n, done, match_cnt} !== {3'b000, 16'd2}) begin
      n_fail++; $display("FAIL stop: busy=%b rst_n=%b done=%b cnt=%0d want 0 0 0 2", busy, cif.cnt_rst_n, done, match_cnt);
    end
    write_entry(0, 16'h55AA, 1'b0);
    pulse_start(1, 1);
    n_checks++;
    if ({cif.setup, cif.desc} !== {16'h55AA, 1'b0}) begin
      n_fail++; $display("FAIL stop_cfg: setup=%h desc=%b want 55aa 0", cif.setup, cif.desc);
    end
    pulse_stop();
  endtask

  task automatic test_match_held();
    write_entry(0, 16'h0033, 1'b1);
    cif.match = 1'b1;
    pulse_start(1, 1);
    step();
    cfg_we = 1'b1; cfg_addr = '0; cfg_value = 16'hBEEF; cfg_desc = 1'b0;
    step();
    cfg_we = 1'b0;
    step(); step();
    n_checks++;
    if ({busy, cif.cnt_rst_n, match_cnt} !== {2'b11, 16'd0}) begin
      n_fail++; $display("FAIL held_no_advance: busy=%b rst_n=%b cnt=%0d want 1 1 0", busy, cif.cnt_rst_n, match_cnt);
    end
    cif.match = 1'b0; step();
    cif.match = 1'b1; step(); cif.match = 1'b0;
    n_checks++;
    if (match_cnt !== 16'd1) begin
      n_fail++; $display("FAIL held_rise: cnt=%0d want 1", match_cnt);
    end
    step(); step();
    pulse_start(1, 1);
    n_checks++;
    if ({cif.setup, cif.desc} !== {16'h0033, 1'b1}) begin
      n_fail++; $display("FAIL cfg_in_run: setup=%h desc=%b want 0033 1", cif.setup, cif.desc);
    end
    pulse_stop();
  endtask

  task automatic test_async_reset();
    pulse_start(2, 1);
    step();
    cif.match = 1'b1; step(); cif.match = 1'b0;
    step(); step();
    n_checks++;
    if ({idx, cif.setup, match_cnt, cif.cnt_rst_n} !== {2'd1, 16'h0007, 16'd1, 1'b1}) begin
      n_fail++; $display("FAIL pre_reset: idx=%0d setup=%h cnt=%0d rst_n=%b want 1 0007 1 1", idx, cif.setup, match_cnt, cif.cnt_rst_n);
    end
    #3 rst = 1'b1;
    #1;
    n_checks++;
    if ({cif.setup, cif.desc, cif.cnt_rst_n, busy, done, idx, match_cnt} !== '0) begin
      n_fail++; $display("FAIL async_reset: setup=%h desc=%b rst_n=%b busy=%b idx=%0d cnt=%0d want all 0",
                         cif.setup, cif.desc, cif.cnt_rst_n, busy, idx, match_cnt);
    end
    #3 rst = 1'b0;
    step();
    pulse_start(1, 1);
    n_checks++;
    if ({cif.setup, cif.desc, busy} !== {16'h0000, 2'b01}) begin
      n_fail++; $display("FAIL post_reset_table: setup=%h desc=%b busy=%b want 0000 0 1", cif.setup, cif.desc, busy);
    end
    pulse_stop();
  endtask

  task automatic test_watchdog();
    pulse_start(1, 1);
    step();
`ifdef COUNTER_SEQ_TIMEOUT_EN
    for (int i = 1; i < 16; i++) step();
    n_checks++;
    if ({busy, err} !== 2'b10) begin
      n_fail++; $display("FAIL wd_before: busy=%b err=%b want 1 0", busy, err);
    end
    step();
    n_checks++;
    if ({busy, err, done, cif.cnt_rst_n} !== 4'b0100) begin
      n_fail++; $display("FAIL wd_expire: busy=%b err=%b done=%b rst_n=%b want 0 1 0 0", busy, err, done, cif.cnt_rst_n);
    end
    step();
    pulse_start(1, 1);
    n_checks++;
    if ({busy, err} !== 2'b10) begin
      n_fail++; $display("FAIL wd_clear: busy=%b err=%b want 1 0", busy, err);
    end
`else
    for (int i = 0; i < 20; i++) step();
    n_checks++;
    if ({busy, err, match_cnt} !== {2'b10, 16'd0}) begin
      n_fail++; $display("FAIL no_wd: busy=%b err=%b cnt=%0d want 1 0 0", busy, err, match_cnt);
    end
`endif
    pulse_stop();
  endtask

  initial begin
    test_reset();
    test_table_replay();
    test_single_entry();
    test_stop();
    test_match_held();
    test_async_reset();
    test_watchdog();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
